// File: rtl/systolic_ctrl_if.sv
// systolic_ctrl_if: job control, weight/data row streams and array drive/result signals
// master = job/array side, slave = controller
interface systolic_ctrl_if #(parameter int data_size = 8, parameter int size = 3);
  localparam int n = data_size * size;
  logic         start;
  logic         keep_w;
  logic [n-1:0] w_in;
  logic         w_valid;
  logic         w_ready;
  logic [n-1:0] d_in;
  logic         d_valid;
  logic         d_ready;
  logic         set_w;
  logic [n-1:0] w_stream;
  logic [n-1:0] data_stream;
  logic [n-1:0] y_stream;
  logic [n-1:0] y_out;
  logic         y_valid;
  logic         busy;
  logic         done;
  modport master (
    output start, keep_w, w_in, w_valid, d_in, d_valid, y_stream,
    input  w_ready, d_ready, set_w, w_stream, data_stream, y_out, y_valid, busy, done
  );
  modport slave (
    input  start, keep_w, w_in, w_valid, d_in, d_valid, y_stream,
    output w_ready, d_ready, set_w, w_stream, data_stream, y_out, y_valid, busy, done
  );
endinterface

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: loads weights and input rows, skews rows into a systolic array, qualifies results
// Optional weight reuse across jobs: define SYSTOLIC_CTRL_REUSE_W_EN
module systolic_ctrl #(
  parameter int data_size = 8,
  parameter int size      = 3,
  parameter int y_lat     = 3
) (
  input logic           clk,
  input logic           rst_n,
  systolic_ctrl_if.slave bus
);
  localparam int n  = data_size * size;
  localparam int cw = $clog2(2 * size + y_lat + 1);
  localparam int bw = size > 1 ? $clog2(size) : 1;
  localparam logic [cw-1:0] last_beat = cw'(size - 1);
  localparam logic [cw-1:0] last_k    = cw'(2 * size - 2);
  localparam logic [cw-1:0] first_y   = cw'(y_lat);
  localparam logic [cw-1:0] last_y    = cw'(y_lat + 2 * size - 2);
`ifdef SYSTOLIC_CTRL_REUSE_W_EN
  localparam bit reuse = 1'b1;
`else
  localparam bit reuse = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, STREAM, FLUSH, DONE} state_t;
  state_t          r_state;
  logic [cw-1:0]   r_cnt;
  logic            r_w_loaded;
  logic [n-1:0]    r_buf [size];
  logic            w_w_acc;
  logic            w_skip;
  logic [n-1:0]    w_data;
  assign w_w_acc = r_state == LOAD_W && bus.w_valid;
  assign w_skip  = reuse & bus.keep_w & r_w_loaded;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_w_loaded <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.start) begin
          r_state <= w_skip ? LOAD_D : LOAD_W;
          r_cnt   <= '0;
        end
        LOAD_W: if (bus.w_valid) begin
          r_cnt <= r_cnt == last_beat ? '0 : r_cnt + cw'(1);
          if (r_cnt == last_beat) begin
            r_state    <= LOAD_D;
            r_w_loaded <= 1'b1;
          end
        end
        LOAD_D: if (bus.d_valid) begin
          r_buf[r_cnt[bw-1:0]] <= bus.d_in;
          r_cnt <= r_cnt == last_beat ? '0 : r_cnt + cw'(1);
          if (r_cnt == last_beat) r_state <= STREAM;
        end
        STREAM: begin
          r_cnt <= r_cnt + cw'(1);
          if (r_cnt == last_k) r_state <= y_lat == 0 ? DONE : FLUSH;
        end
        FLUSH: begin
          r_cnt <= r_cnt + cw'(1);
          if (r_cnt == last_y) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  // k-c wraps to a value >= size when k < c, so one compare covers both bounds
  for (genvar c = 0; c < size; c++) begin : g_lane
    logic [cw-1:0] w_r;
    assign w_r = r_cnt - cw'(c);
    assign w_data[(size-c)*data_size-1 -: data_size] = r_state == STREAM && w_r < cw'(size)
      ? r_buf[w_r[bw-1:0]][(size-c)*data_size-1 -: data_size] : '0;
  end
  assign bus.data_stream = w_data;
  assign bus.w_ready     = r_state == LOAD_W;
  assign bus.d_ready     = r_state == LOAD_D;
  assign bus.set_w       = w_w_acc;
  assign bus.w_stream    = w_w_acc ? bus.w_in : '0;
  assign bus.busy        = r_state != IDLE;
  assign bus.done        = r_state == DONE;
  assign bus.y_valid     = (r_state == STREAM || r_state == FLUSH) && r_cnt >= first_y && r_cnt <= last_y;
  assign bus.y_out       = bus.y_valid ? bus.y_stream : '0;
endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: table of jobs driven cycle by cycle; skewed data and results checked from queues
module tb_systolic_ctrl;
  localparam int dw = 8, sz = 3, yl = 3, n = dw * sz, nk = 2 * sz - 1;
`ifdef SYSTOLIC_CTRL_REUSE_W_EN
  localparam bit reuse = 1'b1;
`else
  localparam bit reuse = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  systolic_ctrl_if #(.data_size(dw), .size(sz)) bus ();
  systolic_ctrl #(.data_size(dw), .size(sz), .y_lat(yl)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [n-1:0] w [sz];
    logic [n-1:0] d [sz];
    int wgap;
    int dgap;
    bit kw;
    bit mid;
    int abort_k;
    logic [n-1:0] exp_ds [nk];
  } vec_t;
  vec_t vecs [6];
  int n_chk = 0, n_err = 0, gc = 0;
  bit w_loaded = 1'b0;
  logic [n-1:0] q_ds [$];
  logic [n-1:0] q_y [$];

  function automatic logic [n-1:0] yf(input int g);
    logic [7:0] b;
    b = g[7:0];
    return {b, b ^ 8'ha5, ~b};
  endfunction

  function automatic logic [n-1:0] skew(input logic [n-1:0] d [sz], input int k);
    logic [n-1:0] r;
    r = '0;
    for (int c = 0; c < sz; c++)
      if (k - c >= 0 && k - c < sz) r[(sz-c)*dw-1 -: dw] = d[k-c][(sz-c)*dw-1 -: dw];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, gc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    gc++;
    bus.y_stream = yf(gc);
  endtask

  task automatic idle_in();
    bus.start = 1'b0; bus.keep_w = 1'b0; bus.w_valid = 1'b0; bus.d_valid = 1'b0;
    bus.w_in = '0; bus.d_in = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_w_ready"}, 32'(bus.w_ready), 0);
    chk({tag, "_d_ready"}, 32'(bus.d_ready), 0);
    chk({tag, "_set_w"}, 32'(bus.set_w), 0);
    chk({tag, "_w_stream"}, 32'(bus.w_stream), 0);
    chk({tag, "_data_stream"}, 32'(bus.data_stream), 0);
    chk({tag, "_y_valid"}, 32'(bus.y_valid), 0);
    chk({tag, "_y_out"}, 32'(bus.y_out), 0);
  endtask

  task automatic run_job(input vec_t v);
    int ph = 0, wb = 0, db = 0, gw = 0, gd = 0, k = 0, nsw = 0, nyv = 0, cyc = 0, exp_sw;
    bit fin = 1'b0;
    logic [n-1:0] e;
    exp_sw = (reuse && v.kw && w_loaded) ? 0 : sz;
    q_ds.delete();
    q_y.delete();
    while (!fin && cyc < 100) begin
      tick();
      cyc++;
      idle_in();
      if (ph == 0) begin
        bus.start = 1'b1; bus.keep_w = v.kw; bus.w_valid = 1'b1; bus.w_in = n'($urandom);
      end else if (ph == 1) begin
        if (wb == 1 && gw < v.wgap) gw++;
        else begin bus.w_valid = 1'b1; bus.w_in = v.w[wb]; end
      end else if (ph == 2) begin
        bus.start = v.mid && db == 0;
        if (db == 1 && gd < v.dgap) gd++;
        else begin bus.d_valid = 1'b1; bus.d_in = v.d[db]; end
      end else begin
        bus.start = v.mid && k == 0;
        bus.w_valid = 1'b1; bus.d_valid = 1'b1;
        bus.w_in = n'($urandom); bus.d_in = n'($urandom);
      end
      #1;
      chk("busy", 32'(bus.busy), 32'(ph != 0));
      chk("w_ready", 32'(bus.w_ready), 32'(ph == 1));
      chk("d_ready", 32'(bus.d_ready), 32'(ph == 2));
      chk("set_w", 32'(bus.set_w), 32'(ph == 1 && bus.w_valid));
      chk("w_stream", 32'(bus.w_stream), (ph == 1 && bus.w_valid) ? 32'(v.w[wb]) : 0);
      if (ph == 3 && k < nk) begin
        if (q_ds.size() == 0) begin n_chk++; n_err++; $display("FAIL ds_queue: empty, required an entry"); end
        else begin e = q_ds.pop_front(); chk("data_stream", 32'(bus.data_stream), 32'(e)); end
      end else chk("data_stream_idle", 32'(bus.data_stream), 0);
      chk("y_valid", 32'(bus.y_valid), 32'(ph == 3 && k >= yl && k <= yl + nk - 1));
      if (bus.y_valid) begin
        nyv++;
        if (q_y.size() == 0) begin n_chk++; n_err++; $display("FAIL y_extra: y_valid with no expected beat"); end
        else begin e = q_y.pop_front(); chk("y_out", 32'(bus.y_out), 32'(e)); end
      end else chk("y_out_idle", 32'(bus.y_out), 0);
      chk("done", 32'(bus.done), 32'(ph == 3 && k == yl + nk));
      nsw += int'(bus.set_w);
      if (ph == 3 && k == v.abort_k) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle_in();
        #1;
        chk_quiet("after_reset");
        w_loaded = 1'b0;
        return;
      end
      case (ph)
        0: ph = (reuse && v.kw && w_loaded) ? 2 : 1;
        1: if (bus.w_valid) begin wb++; if (wb == sz) begin ph = 2; w_loaded = 1'b1; end end
        2: if (bus.d_valid) begin
             db++;
             if (db == sz) begin
               ph = 3; k = 0;
               for (int j = 0; j < nk; j++) begin
                 q_ds.push_back(v.exp_ds[j]);
                 q_y.push_back(yf(gc + 1 + yl + j));
               end
             end
           end
        default: begin if (k == yl + nk) fin = 1'b1; k++; end
      endcase
    end
    if (!fin) begin n_err++; $display("FAIL timeout: job did not finish in 100 cycles"); end
    chk("set_w_beats", 32'(nsw), 32'(exp_sw));
    chk("y_valid_count", 32'(nyv), 32'(nk));
    repeat (2) begin
      tick();
      idle_in();
      #1;
      chk("post_busy", 32'(bus.busy), 0);
      chk("post_done", 32'(bus.done), 0);
    end
  endtask

  initial begin
    vecs[0].w = '{24'h010203, 24'h040506, 24'h070809};
    vecs[0].d = '{24'h010000, 24'h000100, 24'h000001};
    vecs[0].exp_ds = '{24'h010000, 24'h000000, 24'h000100, 24'h000000, 24'h000001};
    for (int i = 1; i < 6; i++)
      for (int r = 0; r < sz; r++) begin
        vecs[i].w[r] = n'($urandom);
        vecs[i].d[r] = n'($urandom);
      end
    vecs[5].d = vecs[4].d;
    for (int i = 0; i < 6; i++) begin
      vecs[i].wgap = 0; vecs[i].dgap = 0; vecs[i].kw = 1'b0; vecs[i].mid = 1'b0; vecs[i].abort_k = -1;
      if (i > 0) for (int k = 0; k < nk; k++) vecs[i].exp_ds[k] = skew(vecs[i].d, k);
    end
    vecs[1].wgap = 2;
    vecs[2].dgap = 1; vecs[2].mid = 1'b1;
    vecs[3].abort_k = 2;
    vecs[4].kw = 1'b1;
    vecs[5].kw = 1'b1;
    idle_in();
    bus.y_stream = '0;
    repeat (2) tick();
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) run_job(vecs[i]);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
